// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for shift_sequencer.
// master: the issuing side (drives requests, accepts results).
// slave:  the sequencer itself.
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_operand;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;

    modport master (
        output in_valid,
        output in_op,
        output in_operand,
        output in_amt,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result
    );

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_operand,
        input  in_amt,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift-unit controller around a single shared left barrel shifter.
// SLL/SRL take one pass; SRA/ROL take two passes unless the amount is zero.
// Right shifts reuse the left shifter by bit-reversing its input and output.
// Optional build macro SHIFT_SEQ_PERF_EN adds a saturating completed-op counter perf_ops.
module shift_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
) (
    input  logic              clock,
    input  logic              resetn,
    shift_sequencer_if.slave  bus,
    output logic              busy
`ifdef SHIFT_SEQ_PERF_EN
    ,
    output logic [15:0]       perf_ops
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StP1   = 2'b01,
        StP2   = 2'b10,
        StDone = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        OpSll = 2'b00,
        OpSrl = 2'b01,
        OpSra = 2'b10,
        OpRol = 2'b11
    } op_e;

    // Full width as an AMT_W+1 bit quantity, used for the (WIDTH - amt) rotate amount.
    localparam logic [AMT_W:0] WidthW = (AMT_W+1)'(WIDTH);

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [WIDTH-1:0] temp_q, temp_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Shared shifter ports
    logic [WIDTH-1:0] sh_in;
    logic [AMT_W-1:0] sh_amt;
    logic [WIDTH-1:0] sh_out;

    logic             accept;
    logic             two_pass;
    logic             right_op;
    logic [WIDTH-1:0] p1_val;
    logic [AMT_W:0]   rol_amt_full;

    // Handshake outputs decoded from the current state
    always_comb begin
        bus.in_ready   = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
        bus.out_valid  = (state_q == StDone);
        bus.out_result = result_q;
        busy           = (state_q != StIdle);
    end

    assign accept       = bus.in_valid && bus.in_ready;
    assign two_pass     = ((op_q == OpSra) || (op_q == OpRol)) && (amt_q != '0);
    assign right_op     = (op_q == OpSrl) || (op_q == OpSra);
    assign rol_amt_full = WidthW - {1'b0, amt_q};

    // Shifter operand/amount select; fed only from latched request registers
    always_comb begin
        sh_in  = operand_q;
        sh_amt = amt_q;
        unique case (state_q)
            StP1: begin
                sh_in  = right_op ? rev(operand_q) : operand_q;
                sh_amt = amt_q;
            end
            StP2: begin
                if (op_q == OpSra) begin
                    // Fill mask: ones shifted left, reversed and inverted gives the top amt bits
                    sh_in  = '1;
                    sh_amt = amt_q;
                end else begin
                    // Wrap-around part of the rotate: operand >> (WIDTH - amt)
                    sh_in  = rev(operand_q);
                    sh_amt = rol_amt_full[AMT_W-1:0];
                end
            end
            default: begin
                sh_in  = operand_q;
                sh_amt = amt_q;
            end
        endcase
    end

    // The single combinational left barrel shifter
    always_comb begin
        sh_out = sh_in << sh_amt;
    end

    // Pass-1 value, un-reversed for right shifts
    assign p1_val = right_op ? rev(sh_out) : sh_out;

    // Next-state and datapath register updates
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        amt_d     = amt_q;
        temp_d    = temp_q;
        result_d  = result_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = op_e'(bus.in_op);
                    operand_d = bus.in_operand;
                    amt_d     = bus.in_amt;
                    state_d   = StP1;
                end
            end
            StP1: begin
                temp_d = p1_val;
                if (two_pass) begin
                    state_d = StP2;
                end else begin
                    // Single-pass ops, and SRA/ROL by zero, finish here
                    result_d = p1_val;
                    state_d  = StDone;
                end
            end
            StP2: begin
                if (op_q == OpSra) begin
                    result_d = operand_q[WIDTH-1] ? (temp_q | ~rev(sh_out)) : temp_q;
                end else begin
                    result_d = temp_q | rev(sh_out);
                end
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        // Retire current result and take the next request on the same edge
                        op_d      = op_e'(bus.in_op);
                        operand_d = bus.in_operand;
                        amt_d     = bus.in_amt;
                        state_d   = StP1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            op_q      <= OpSll;
            operand_q <= '0;
            amt_q     <= '0;
            temp_q    <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            amt_q     <= amt_d;
            temp_q    <= temp_d;
            result_q  <= result_d;
        end
    end

`ifdef SHIFT_SEQ_PERF_EN
    logic [15:0] perf_q;

    // Saturating count of completed result handshakes
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perf_q <= '0;
        end else if (bus.out_valid && bus.out_ready && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_ops = perf_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

    logic clock = 1'b0;
    logic resetn;
    logic busy;
`ifdef SHIFT_SEQ_PERF_EN
    logic [15:0] perf_ops;
    logic [15:0] perf_start;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    shift_sequencer_if sif ();

    shift_sequencer dut (
        .clock   (clock),
        .resetn  (resetn),
        .bus     (sif),
        .busy    (busy)
`ifdef SHIFT_SEQ_PERF_EN
        ,
        .perf_ops(perf_ops)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural reference, independent of the pass structure in the design
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] x,
                                              input logic [4:0] a);
        logic [63:0] dbl;
        case (op)
            2'b00:   return x << a;
            2'b01:   return x >> a;
            2'b10:   return 32'($signed(x) >>> a);
            default: begin
                dbl = {x, x} << a;
                return dbl[63:32];
            end
        endcase
    endfunction

    // Issue one request at a negedge, wait for the result, check, then retire it
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                         input logic [4:0] a, input logic [31:0] exp);
        int lat;
        int exp_lat;
        exp_lat = ((op == 2'b10 || op == 2'b11) && a != 5'd0) ? 3 : 2;
        sif.in_valid   = 1'b1;
        sif.in_op      = op;
        sif.in_operand = x;
        sif.in_amt     = a;
        sif.out_ready  = 1'b0;
        check({tag, "/in_ready"}, 32'(sif.in_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        sif.in_valid = 1'b0;
        lat = 1;
        while (!sif.out_valid && lat < 10) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/result"}, sif.out_result, exp);
        sif.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        sif.out_ready = 1'b0;
        check({tag, "/retired"}, 32'(sif.out_valid), 32'd0);
    endtask

    initial begin
        resetn         = 1'b0;
        sif.in_valid   = 1'b0;
        sif.in_op      = 2'b00;
        sif.in_operand = '0;
        sif.in_amt     = '0;
        sif.out_ready  = 1'b0;
        #2;
        check("reset/in_ready", 32'(sif.in_ready), 32'd1);
        check("reset/out_valid", 32'(sif.out_valid), 32'd0);
        check("reset/out_result", sif.out_result, 32'h0);
        check("reset/busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Basic ops with hand-computed results
        do_op("sll4", 2'b00, 32'hF1A7372F, 5'd4, 32'h1A7372F0);
        do_op("srl4", 2'b01, 32'hF1A7372F, 5'd4, 32'h0F1A7372);
        do_op("sra4", 2'b10, 32'hF1A7372F, 5'd4, 32'hFF1A7372);
        do_op("sra31_pos", 2'b10, 32'h70000000, 5'd31, 32'h00000000);
        do_op("sra31_neg", 2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF);
        do_op("rol8", 2'b11, 32'hF1A7372F, 5'd8, 32'hA7372FF1);
        do_op("rol0", 2'b11, 32'hF1A7372F, 5'd0, 32'hF1A7372F);
        do_op("sra0", 2'b10, 32'h80000001, 5'd0, 32'h80000001);

        // Backpressure in DONE, then same-edge retire and accept
        sif.in_valid   = 1'b1;
        sif.in_op      = 2'b01;
        sif.in_operand = 32'hF1A7372F;
        sif.in_amt     = 5'd4;
        @(posedge clock);
        @(negedge clock);
        sif.in_op      = 2'b00;
        sif.in_operand = 32'h00000001;
        sif.in_amt     = 5'd31;
        @(posedge clock);
        @(negedge clock);
        check("hold/enter_done", 32'(sif.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("hold/result", sif.out_result, 32'h0F1A7372);
            check("hold/in_ready", 32'(sif.in_ready), 32'd0);
            check("hold/out_valid", 32'(sif.out_valid), 32'd1);
        end
        sif.out_ready = 1'b1;
        #1;
        check("b2b/in_ready", 32'(sif.in_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b0;
        check("b2b/out_valid_drop", 32'(sif.out_valid), 32'd0);
        check("b2b/busy", 32'(busy), 32'd1);
        @(posedge clock);
        @(negedge clock);
        check("b2b/out_valid", 32'(sif.out_valid), 32'd1);
        check("b2b/result", sif.out_result, 32'h80000000);
        sif.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        sif.out_ready = 1'b0;
        check("b2b/idle", 32'(busy), 32'd0);

        // Reset in the middle of the second SRA pass
        sif.in_valid   = 1'b1;
        sif.in_op      = 2'b10;
        sif.in_operand = 32'hF1A7372F;
        sif.in_amt     = 5'd4;
        @(posedge clock);
        @(negedge clock);
        sif.in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("abort/in_p2_busy", 32'(busy), 32'd1);
        check("abort/in_p2_valid", 32'(sif.out_valid), 32'd0);
        resetn = 1'b0;
        #1;
        check("abort/in_ready", 32'(sif.in_ready), 32'd1);
        check("abort/out_valid", 32'(sif.out_valid), 32'd0);
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/out_result", sif.out_result, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("abort/no_emit", 32'(sif.out_valid), 32'd0);
        end

`ifdef SHIFT_SEQ_PERF_EN
        perf_start = perf_ops;
`endif
        // Sweep all amounts and ops against the reference model
        for (int op = 0; op < 4; op++) begin
            for (int a = 0; a < 32; a++) begin
                do_op($sformatf("sweep_op%0d_amt%0d", op, a), 2'(op), 32'hF1A7372F, 5'(a),
                      ref_model(2'(op), 32'hF1A7372F, 5'(a)));
            end
        end
`ifdef SHIFT_SEQ_PERF_EN
        check("perf/sweep", 32'(perf_ops - perf_start), 32'd128);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle shift-unit controller built around one shared instance of the combinational 32-bit left barrel shifter `lshift`.
- Accepts shift requests over a valid/ready handshake and presents results over a second valid/ready handshake.
- Implements SLL, SRL, SRA and ROL by sequencing one or two passes through the single shifter, using input/output bit-reversal muxes and mask generation.
- Sits between the ALU issue logic and the writeback stage.

Parameters:
WIDTH, 32, datapath width; must be 32 to match `lshift`
AMT_W, 5, shift-amount width; must equal log2(WIDTH)

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  sequencer can accept a request this cycle
in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
in_operand  in  WIDTH  value to shift
in_amt  in  AMT_W  shift amount, 0..31
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  shifted value
busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, P1, P2, DONE.
- Reset (async, resetn=0): state=IDLE, in_ready=1, out_valid=0, out_result=0, busy=0. All internal registers clear.
- Accept: in_valid&in_ready at an edge latches op, operand and amt, then moves to P1.
- The shifter's operand and amount are driven only from latched registers, never from the in_* ports.
- in_ready is high in IDLE, and in DONE when out_ready=1 (back-to-back accept). It is low in P1 and P2.
- P1 (the edge leaving P1 captures the pass-1 result):
  - SLL: shift operand by amt; result final.
  - SRL: shift rev(operand) by amt; result = rev(shifter output).
  - SRA: the same as SRL; the logical part is held in a temp register.
  - ROL: shift operand by amt; held in temp.
  - Two-pass ops (SRA, ROL) with amt≠0 go to P2. All other cases go to DONE.
- P2 (the edge leaving P2 completes the op, then DONE):
  - SRA: shift 0xFFFFFFFF by amt. If operand[31]=1, result = temp | ~rev(shifter output); else result = temp.
  - ROL: shift rev(operand) by (32-amt) mod 32. result = temp | rev(shifter output).
- amt=0: SRA and ROL complete in one pass. The result equals the operand.
- Latency, counted from the accept edge:
  - out_valid rises after 2 edges for single-pass ops.
  - out_valid rises after 3 edges for two-pass ops with amt≠0.
- DONE: out_valid=1 and out_result is held stable until out_ready=1.
  - out_ready=1 and in_valid=0: go to IDLE; out_valid drops on the next edge.
  - out_ready=1 and in_valid=1 (simultaneous complete and accept): retire the current result and latch the new request in the same edge; go to P1.
  - out_ready=0: stay in DONE; ignore in_valid.
- out_ready is ignored outside DONE.
- resetn asserted in P1, P2 or DONE aborts the op immediately. The result is discarded; no out_valid is produced.
- All arithmetic is modulo 2^32. (32-amt) is computed in AMT_W+1 bits, then truncated to AMT_W bits.

Optional Feature:
SHIFT_SEQ_PERF_EN:
- Defined: adds output perf_ops[15:0].
  - Increments on each completed handshake (out_valid&out_ready).
  - Saturates at 0xFFFF.
  - Resets to 0 on resetn=0.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
1. Reset, then SLL 0xF1A7372F amt=4 -> out_result=0x1A7372F0; out_valid exactly 2 edges after accept.
2. SRL 0xF1A7372F amt=4 -> 0x0F1A7372. SRA same operand amt=4 -> 0xFF1A7372 after 3 edges. SRA 0x70000000 amt=31 -> 0x00000000. SRA 0x80000000 amt=31 -> 0xFFFFFFFF.
3. ROL 0xF1A7372F amt=8 -> 0xA7372FF1 after 3 edges. ROL amt=0 -> 0xF1A7372F after 2 edges.
4. Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> result stable, in_ready=0, nothing accepted. Then raise out_ready with a new SLL 0x00000001 amt=31 pending -> same-edge accept; next result 0x80000000.
5. Pull resetn low mid-P2 of an SRA -> immediate IDLE, out_valid=0, in_ready=1. The op is never emitted.
6. Sweep amt 0..31 for all four ops on 0xF1A7372F against a reference model -> 128/128 match. With SHIFT_SEQ_PERF_EN defined, perf_ops=128.
